// File: rtl/lsb.sv
// Load/store buffer: in-order memory ops between dispatch and a byte-serial memory port.
// Pending operands are resolved from the ROB broadcast. Loads run at the head and report
// to the ROB. Stores run only after the ROB commits them.
// Optional: define LSB_IO_STALL_EN to hold IO-space loads (addr >= 0x30000) until they
// reach the ROB head.
module lsb #(
  parameter int ROB_WIDTH = 4,
  parameter int LSB_WIDTH = 3,
  parameter int LSB_SIZE  = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 from_decoder,
  input  logic                 dec_is_store,
  input  logic [2:0]           dec_funct3,
  input  logic [ROB_WIDTH-1:0] dec_tag,
  input  logic                 dec_rs1_busy,
  input  logic [ROB_WIDTH-1:0] dec_rs1_tag,
  input  logic [31:0]          dec_rs1_val,
  input  logic                 dec_rs2_busy,
  input  logic [ROB_WIDTH-1:0] dec_rs2_tag,
  input  logic [31:0]          dec_rs2_val,
  input  logic [31:0]          dec_imm,
  input  logic                 rob_update,
  input  logic [ROB_WIDTH-1:0] rob_update_tag,
  input  logic [31:0]          rob_update_wdata,
  input  logic                 rob_commit,
  input  logic [ROB_WIDTH-1:0] rob_commit_tag,
  input  logic [ROB_WIDTH-1:0] rob_head,
  input  logic [7:0]           mem_din,
  input  logic                 io_buffer_full,
  output logic [7:0]           mem_dout,
  output logic [31:0]          mem_a,
  output logic                 mem_wr,
  output logic                 lsb_full,
  output logic                 to_rob,
  output logic [ROB_WIDTH-1:0] to_rob_tag,
  output logic [31:0]          to_rob_wdata
);
  typedef logic [ROB_WIDTH-1:0] tag_t;
  typedef struct packed {
    logic        valid;
    logic        committed;
    logic        is_store;
    logic [2:0]  funct3;
    tag_t        tag;
    logic        rs1_busy;
    tag_t        rs1_tag;
    logic [31:0] rs1_val;
    logic        rs2_busy;
    tag_t        rs2_tag;
    logic [31:0] rs2_val;
    logic [31:0] imm;
  } ent_t;
  typedef enum logic [1:0] {IDLE, LOAD, DONE, STORE} state_t;

  state_t                 state, state_nxt;
  ent_t                   q [LSB_SIZE];
  ent_t                   hd, new_ent;
  logic [LSB_WIDTH-1:0]   head, tail, idx;
  logic [LSB_WIDTH:0]     count, keep_cnt;
  logic [LSB_SIZE-1:0]    keep_mask;
  logic                   run, enq, pop, st_adv, is_io, io_hold, ld_io_ok;
  logic [2:0]             byte_idx, nbytes;
  logic [31:0]            addr, ld_data, ld_ext;

  assign hd       = q[head];
  assign addr     = hd.rs1_val + hd.imm;
  assign is_io    = addr >= 32'h0003_0000;
  assign io_hold  = is_io && io_buffer_full;
  assign enq      = from_decoder && !clear;
  assign lsb_full = ({1'b0, count} + (LSB_WIDTH+2)'(2)) >= (LSB_WIDTH+2)'(LSB_SIZE);

`ifdef LSB_IO_STALL_EN
  assign ld_io_ok = !is_io || (rob_head == hd.tag);
`else
  logic unused_rob_head;
  assign ld_io_ok        = 1'b1;
  assign unused_rob_head = ^rob_head;
`endif

  // Access size from funct3: byte, half, word.
  always_comb begin
    case (hd.funct3[1:0])
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  // Sign/zero extension of the assembled load bytes.
  always_comb begin
    case (hd.funct3)
      3'b000:  ld_ext = {{24{ld_data[7]}}, ld_data[7:0]};
      3'b001:  ld_ext = {{16{ld_data[15]}}, ld_data[15:0]};
      3'b100:  ld_ext = {24'b0, ld_data[7:0]};
      3'b101:  ld_ext = {16'b0, ld_data[15:0]};
      default: ld_ext = ld_data;
    endcase
  end

  // Incoming entry, with a same-cycle broadcast already folded in.
  always_comb begin
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.is_store = dec_is_store;
    new_ent.funct3   = dec_funct3;
    new_ent.tag      = dec_tag;
    new_ent.rs1_busy = dec_rs1_busy;
    new_ent.rs1_tag  = dec_rs1_tag;
    new_ent.rs1_val  = dec_rs1_val;
    new_ent.rs2_busy = dec_rs2_busy;
    new_ent.rs2_tag  = dec_rs2_tag;
    new_ent.rs2_val  = dec_rs2_val;
    new_ent.imm      = dec_imm;
    if (rob_update && dec_rs1_busy && dec_rs1_tag == rob_update_tag) begin
      new_ent.rs1_busy = 1'b0;
      new_ent.rs1_val  = rob_update_wdata;
    end
    if (rob_update && dec_rs2_busy && dec_rs2_tag == rob_update_tag) begin
      new_ent.rs2_busy = 1'b0;
      new_ent.rs2_val  = rob_update_wdata;
    end
  end

  // Committed-prefix scan from head: these entries survive a clear.
  // A commit arriving in the clear cycle counts as committed.
  always_comb begin
    keep_mask = '0;
    keep_cnt  = '0;
    run       = 1'b1;
    idx       = '0;
    for (int i = 0; i < LSB_SIZE; i++) begin
      idx = head + LSB_WIDTH'(i);
      if (run && (LSB_WIDTH+1)'(i) < count &&
          (q[idx].committed || (rob_commit && q[idx].valid && q[idx].tag == rob_commit_tag))) begin
        keep_mask[idx] = 1'b1;
        keep_cnt       = keep_cnt + (LSB_WIDTH+1)'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  // Head FSM: next state, memory port and ROB report.
  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    st_adv       = 1'b0;
    mem_wr       = 1'b0;
    mem_a        = '0;
    mem_dout     = '0;
    to_rob       = 1'b0;
    to_rob_tag   = hd.tag;
    to_rob_wdata = '0;
    case (state)
      IDLE: if (!clear && hd.valid) begin
        if (!hd.is_store && !hd.rs1_busy && ld_io_ok)
          state_nxt = LOAD;
        else if (hd.is_store && !hd.rs1_busy && !hd.rs2_busy && hd.committed && !io_hold)
          state_nxt = STORE;
      end
      LOAD: begin
        // byte_idx counts addresses sent; data for byte k arrives while byte_idx == k+1
        if (byte_idx < nbytes) mem_a = addr + 32'(byte_idx);
        if (clear) state_nxt = IDLE;
        else if (byte_idx == nbytes) state_nxt = DONE;
      end
      DONE: begin
        if (clear) state_nxt = IDLE;
        else begin
          to_rob       = rdy_in;
          to_rob_wdata = ld_ext;
          pop          = 1'b1;
          state_nxt    = IDLE;
        end
      end
      STORE: begin
        // committed store always finishes, even across a clear
        mem_a = addr + 32'(byte_idx);
        if (!io_hold) begin
          mem_wr   = rdy_in;
          mem_dout = hd.rs2_val[{byte_idx[1:0], 3'b000} +: 8];
          st_adv   = 1'b1;
          if (byte_idx == nbytes - 3'd1) begin
            pop       = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, byte counter, load data and queue maintenance.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      byte_idx <= '0;
      ld_data  <= '0;
      for (int i = 0; i < LSB_SIZE; i++) q[i] <= '0;
    end else if (rdy_in) begin
      state <= state_nxt;
      case (state)
        LOAD:    byte_idx <= (state_nxt == LOAD) ? byte_idx + 3'd1 : 3'd0;
        STORE:   if (st_adv) byte_idx <= (state_nxt == STORE) ? byte_idx + 3'd1 : 3'd0;
        default: byte_idx <= '0;
      endcase
      if (state == LOAD)
        for (int b = 0; b < 4; b++)
          if (byte_idx == 3'(b + 1)) ld_data[8*b +: 8] <= mem_din;

      for (int i = 0; i < LSB_SIZE; i++) begin
        if (q[i].valid && rob_update) begin
          if (q[i].rs1_busy && q[i].rs1_tag == rob_update_tag) begin
            q[i].rs1_busy <= 1'b0;
            q[i].rs1_val  <= rob_update_wdata;
          end
          if (q[i].rs2_busy && q[i].rs2_tag == rob_update_tag) begin
            q[i].rs2_busy <= 1'b0;
            q[i].rs2_val  <= rob_update_wdata;
          end
        end
        if (q[i].valid && rob_commit && q[i].tag == rob_commit_tag) q[i].committed <= 1'b1;
      end

      if (enq) q[tail] <= new_ent;
      if (pop) begin
        q[head].valid     <= 1'b0;
        q[head].committed <= 1'b0;
        head              <= head + LSB_WIDTH'(1);
      end

      if (clear) begin
        for (int i = 0; i < LSB_SIZE; i++)
          if (!keep_mask[i]) begin
            q[i].valid     <= 1'b0;
            q[i].committed <= 1'b0;
          end
        tail  <= head + keep_cnt[LSB_WIDTH-1:0];
        count <= keep_cnt - (LSB_WIDTH+1)'(pop);
      end else begin
        if (enq) tail <= tail + LSB_WIDTH'(1);
        count <= count + (LSB_WIDTH+1)'(enq) - (LSB_WIDTH+1)'(pop);
      end
    end
  end
endmodule

// File: tb/tb_lsb.sv
// Scoreboard bench for lsb: stimulus pushes expected ROB reports and memory writes into
// queues; a negedge monitor pops and compares whenever the DUT reports or writes.
module tb_lsb;
  logic        clk_in = 0, rst_in = 1, rdy_in = 1, clear = 0;
  logic        from_decoder = 0, dec_is_store = 0;
  logic [2:0]  dec_funct3 = 0;
  logic [3:0]  dec_tag = 0, dec_rs1_tag = 0, dec_rs2_tag = 0;
  logic        dec_rs1_busy = 0, dec_rs2_busy = 0;
  logic [31:0] dec_rs1_val = 0, dec_rs2_val = 0, dec_imm = 0;
  logic        rob_update = 0, rob_commit = 0;
  logic [3:0]  rob_update_tag = 0, rob_commit_tag = 0, rob_head = 0;
  logic [31:0] rob_update_wdata = 0;
  logic [7:0]  mem_din = 0;
  logic        io_buffer_full = 0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, lsb_full, to_rob;
  logic [3:0]  to_rob_tag;
  logic [31:0] to_rob_wdata;

  lsb #(.ROB_WIDTH(4), .LSB_WIDTH(3), .LSB_SIZE(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .from_decoder(from_decoder), .dec_is_store(dec_is_store), .dec_funct3(dec_funct3),
    .dec_tag(dec_tag), .dec_rs1_busy(dec_rs1_busy), .dec_rs1_tag(dec_rs1_tag),
    .dec_rs1_val(dec_rs1_val), .dec_rs2_busy(dec_rs2_busy), .dec_rs2_tag(dec_rs2_tag),
    .dec_rs2_val(dec_rs2_val), .dec_imm(dec_imm), .rob_update(rob_update),
    .rob_update_tag(rob_update_tag), .rob_update_wdata(rob_update_wdata),
    .rob_commit(rob_commit), .rob_commit_tag(rob_commit_tag), .rob_head(rob_head),
    .mem_din(mem_din), .io_buffer_full(io_buffer_full), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .lsb_full(lsb_full), .to_rob(to_rob),
    .to_rob_tag(to_rob_tag), .to_rob_wdata(to_rob_wdata)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { logic [3:0] tag; logic [31:0] data; } rd_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
  rd_t rd_q[$];
  wr_t wr_q[$];
  rd_t rd_e;
  wr_t wr_e;
  logic [7:0] mem [logic [31:0]];
  int checks = 0, errors = 0, cyc = 0, last_rob_cyc = 0, issue_cyc = 0;

  // Memory model: data for an address is presented one cycle later.
  always @(posedge clk_in) begin
    cyc     <= cyc + 1;
    mem_din <= mem.exists(mem_a) ? mem[mem_a] : 8'h00;
  end

  // Monitor: every ROB report and every write must match the next expected item.
  always @(negedge clk_in) if (!rst_in) begin
    if (to_rob) begin
      last_rob_cyc = cyc;
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL to_rob unexpected: tag %0d data %h, nothing expected", to_rob_tag, to_rob_wdata);
      end else begin
        rd_e = rd_q.pop_front();
        if (to_rob_tag !== rd_e.tag || to_rob_wdata !== rd_e.data) begin
          errors++;
          $display("FAIL to_rob: got tag %0d data %h, want tag %0d data %h",
                   to_rob_tag, to_rob_wdata, rd_e.tag, rd_e.data);
        end
      end
    end
    if (mem_wr) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL mem_wr unexpected: addr %h byte %h, nothing expected", mem_a, mem_dout);
      end else begin
        wr_e = wr_q.pop_front();
        if (mem_a !== wr_e.a || mem_dout !== wr_e.d) begin
          errors++;
          $display("FAIL mem_wr: got addr %h byte %h, want addr %h byte %h", mem_a, mem_dout, wr_e.a, wr_e.d);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Enqueue one op; issue_cyc is the first cycle the op can sit at an idle head.
  task automatic enq(input logic st, input logic [2:0] f3, input logic [3:0] tag,
                     input logic r1b, input logic [3:0] r1t, input logic [31:0] r1v,
                     input logic r2b, input logic [3:0] r2t, input logic [31:0] r2v,
                     input logic [31:0] imm);
    from_decoder = 1; dec_is_store = st; dec_funct3 = f3; dec_tag = tag;
    dec_rs1_busy = r1b; dec_rs1_tag = r1t; dec_rs1_val = r1v;
    dec_rs2_busy = r2b; dec_rs2_tag = r2t; dec_rs2_val = r2v; dec_imm = imm;
    tick();
    issue_cyc = cyc;
    from_decoder = 0;
  endtask

  task automatic load(input logic [2:0] f3, input logic [3:0] tag, input logic [31:0] base, input logic [31:0] imm);
    enq(1'b0, f3, tag, 1'b0, 4'd0, base, 1'b0, 4'd0, 32'd0, imm);
  endtask

  task automatic wait_empty(input string name, input int lim);
    int n = 0;
    while ((rd_q.size() != 0 || wr_q.size() != 0) && n < lim) begin tick(); n++; end
    chk(name, 32'(rd_q.size() + wr_q.size()), 32'd0);
  endtask

  // A fresh LB must be the only thing left and run straight from the head.
  task automatic probe(input string name, input logic [3:0] tag);
    rd_q.push_back('{tag, 32'hFFFF_FF80});
    load(3'b000, tag, 32'h200, 32'd0);
    wait_empty(name, 20);
    chk(name, 32'(last_rob_cyc - issue_cyc), 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    mem[32'h104] = 8'h78; mem[32'h105] = 8'h56; mem[32'h106] = 8'h34; mem[32'h107] = 8'h12;
    mem[32'h200] = 8'h80; mem[32'h201] = 8'h9A;
    for (int i = 0; i < 6; i++) mem[32'h400 + i] = 8'hC0 + 8'(i);
    mem[32'h30000] = 8'h44; mem[32'h30001] = 8'h33; mem[32'h30002] = 8'h22; mem[32'h30003] = 8'h11;

    tick(3);
    chk("reset mem_wr", 32'(mem_wr), 0);
    chk("reset mem_a", mem_a, 0);
    chk("reset mem_dout", 32'(mem_dout), 0);
    chk("reset to_rob", 32'(to_rob), 0);
    chk("reset lsb_full", 32'(lsb_full), 0);
    rst_in = 0;
    tick();

    // LW: issue cycle, 4 address cycles, capture lag, DONE -> N+2 = 6
    rd_q.push_back('{4'd1, 32'h1234_5678});
    load(3'b010, 4'd1, 32'h100, 32'd4);
    wait_empty("LW done", 30);
    chk("LW latency", 32'(last_rob_cyc - issue_cyc), 32'd6);

    rd_q.push_back('{4'd2, 32'hFFFF_FF80});
    load(3'b000, 4'd2, 32'h1F0, 32'h10);
    wait_empty("LB done", 20);
    chk("LB latency", 32'(last_rob_cyc - issue_cyc), 32'd3);

    rd_q.push_back('{4'd3, 32'h0000_0080});
    load(3'b100, 4'd3, 32'h200, 32'd0);
    wait_empty("LBU done", 20);

    rd_q.push_back('{4'd4, 32'hFFFF_9A80});
    load(3'b001, 4'd4, 32'h210, 32'hFFFF_FFF0);
    wait_empty("LH negative imm", 20);

    // SW with pending data: nothing may be written until update and commit
    enq(1'b1, 3'b010, 4'd5, 1'b0, 4'd0, 32'h300, 1'b1, 4'd4, 32'd0, 32'd0);
    tick(6);
    rob_update = 1; rob_update_tag = 4'd4; rob_update_wdata = 32'hDEAD_BEEF;
    tick();
    rob_update = 0;
    tick(5);
    wr_q.push_back('{32'h300, 8'hEF}); wr_q.push_back('{32'h301, 8'hBE});
    wr_q.push_back('{32'h302, 8'hAD}); wr_q.push_back('{32'h303, 8'hDE});
    rob_commit = 1; rob_commit_tag = 4'd5;
    tick();
    rob_commit = 0;
    wait_empty("SW writes", 20);

    // Fill across the wrap with loads waiting on tag 15; last enqueue meets the broadcast
    for (int i = 0; i < 6; i++) rd_q.push_back('{4'(6 + i), 32'h0000_00C0 + 32'(i)});
    for (int i = 0; i < 5; i++) enq(1'b0, 3'b100, 4'(6 + i), 1'b1, 4'd15, 32'd0, 1'b0, 4'd0, 32'd0, 32'(i));
    chk("lsb_full at 5", 32'(lsb_full), 0);
    rob_update = 1; rob_update_tag = 4'd15; rob_update_wdata = 32'h400;
    enq(1'b0, 3'b100, 4'd11, 1'b1, 4'd15, 32'd0, 1'b0, 4'd0, 32'd0, 32'd5);
    rob_update = 0;
    chk("lsb_full at 6", 32'(lsb_full), 1);
    wait_empty("wrap drain", 100);
    chk("lsb_full drained", 32'(lsb_full), 0);

    // Clear during a load: no report, queue empty afterwards
    load(3'b010, 4'd1, 32'h100, 32'd4);
    load(3'b010, 4'd2, 32'h100, 32'd4);
    load(3'b010, 4'd3, 32'h100, 32'd4);
    clear = 1; tick(); clear = 0;
    tick(12);
    probe("probe after load clear", 4'd9);

    // Committed SB held by IO back-pressure, 3 uncommitted loads behind it, then clear
    io_buffer_full = 1;
    enq(1'b1, 3'b000, 4'd4, 1'b0, 4'd0, 32'h30000, 1'b0, 4'd0, 32'h0000_00A5, 32'd0);
    rob_commit = 1; rob_commit_tag = 4'd4; tick(); rob_commit = 0;
    load(3'b010, 4'd5, 32'h100, 32'd4);
    load(3'b010, 4'd6, 32'h100, 32'd4);
    load(3'b010, 4'd7, 32'h100, 32'd4);
    tick(3);
    chk("IO store held", 32'(mem_wr), 0);
    clear = 1; tick(); clear = 0;
    wr_q.push_back('{32'h30000, 8'hA5});
    io_buffer_full = 0;
    wait_empty("SB after clear", 20);
    tick(12);
    probe("probe after store clear", 4'd8);

    // IO-space load
    rob_head = 4'd0;
`ifdef LSB_IO_STALL_EN
    begin
      int seen = 0;
      load(3'b010, 4'd14, 32'h30000, 32'd0);
      for (int i = 0; i < 8; i++) begin
        if (mem_a == 32'h30000) seen = 1;
        tick();
      end
      chk("IO load stalled", 32'(seen), 0);
      rd_q.push_back('{4'd14, 32'h1122_3344});
      rob_head = 4'd14;
      wait_empty("IO load at rob head", 30);
    end
`else
    rd_q.push_back('{4'd14, 32'h1122_3344});
    load(3'b010, 4'd14, 32'h30000, 32'd0);
    wait_empty("IO load", 30);
`endif

    tick(5);
    chk("scoreboard empty", 32'(rd_q.size() + wr_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
